// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle unsigned MUL / DIVU / REMU sequencer driving one
// shared ALU. It owns the ALU cmd/operands while iterating and drives a
// neutral AND 0,0 command whenever it is idle or holding a result.
//
// Optional feature macro: ALU_SEQ_EARLY_EXIT_EN
//   When defined, a multiply finishes as soon as the remaining multiplier
//   bits are all zero instead of always running ITERS iterations.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only while IDLE)
//   req_op             00 MUL low word, 01 DIVU, 10 REMU, 11 reserved
//   req_a, req_b       multiplicand/dividend, multiplier/divisor
//   resp_valid/ready   response handshake
//   resp_data          result, stable while resp_valid is high
//   alu_cmd/a/b        command and operands to the shared ALU
//   alu_out            result from the shared ALU
//   busy               high while iterating (MUL or DIV state)

package alu_seq_pkg;
  typedef logic [31:0] op_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_cmd_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic [1:0] req_op,
  input  op_t      req_a,
  input  op_t      req_b,
  output logic     resp_valid,
  input  logic     resp_ready,
  output op_t      resp_data,
  output alu_cmd_t alu_cmd,
  output op_t      alu_a,
  output op_t      alu_b,
  input  op_t      alu_out,
  output logic     busy
);

  localparam int CW = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  op_t           acc;
  op_t           mcand;
  op_t           mplier;
  op_t           rem;
  op_t           dvd;
  op_t           divisor;
  op_t           quo;
  logic [CW-1:0] cnt;
  logic          op_rem;

  logic [32:0] trial;
  logic        trial_ge;
  op_t         acc_next;
  op_t         rem_next;
  op_t         quo_next;
  op_t         mplier_shift;
  logic        last_iter;
  logic        mul_exit;

  // Restoring division: bring the next dividend bit into the partial
  // remainder. The compare is 33 bits wide because the shifted remainder can
  // exceed 32 bits; when it does, the ALU's 32-bit difference is still exact.
  assign trial     = {rem, dvd[31]};
  assign trial_ge  = (trial >= {1'b0, divisor});
  assign rem_next  = trial_ge ? alu_out : trial[31:0];
  assign quo_next  = {quo[30:0], trial_ge};

  // Shift-add multiply: the ALU sum is only kept when the current
  // multiplier bit is set.
  assign acc_next     = mplier[0] ? alu_out : acc;
  assign mplier_shift = mplier >> 1;
  assign last_iter    = (cnt == LAST);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  // No set bits left means further iterations would only add zero.
  assign mul_exit = last_iter || (mplier_shift == '0);
`else
  assign mul_exit = last_iter;
`endif

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign busy       = (state == S_MUL) || (state == S_DIV);

  // Next-state selection and ALU drive. The ALU sees a neutral AND 0,0
  // unless an iteration is in flight.
  always_comb begin
    state_next = state;
    alu_cmd    = ALU_AND;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_MUL:  state_next = S_MUL;
            OP_DIVU,
            OP_REMU: state_next = (req_b == '0) ? S_DONE : S_DIV;
            default: state_next = S_DONE;
          endcase
        end
      end
      S_MUL: begin
        alu_cmd = ALU_ADD;
        alu_a   = acc;
        alu_b   = mcand;
        if (mul_exit) state_next = S_DONE;
      end
      S_DIV: begin
        alu_cmd = ALU_SUB;
        alu_a   = trial[31:0];
        alu_b   = divisor;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers. Operands are captured only at accept; the result
  // register is written on the cycle that enters DONE and then held until
  // the response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      dvd       <= '0;
      divisor   <= '0;
      quo       <= '0;
      cnt       <= '0;
      op_rem    <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            acc     <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            mcand   <= req_a;
            mplier  <= req_b;
            dvd     <= req_a;
            divisor <= req_b;
            op_rem  <= (req_op == OP_REMU);
            // Zero-divisor and reserved ops complete without iterating.
            case (req_op)
              OP_MUL:  ;
              OP_DIVU: if (req_b == '0) resp_data <= '1;
              OP_REMU: if (req_b == '0) resp_data <= req_a;
              default: resp_data <= '0;
            endcase
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_shift;
          cnt    <= cnt + 1'b1;
          if (mul_exit) resp_data <= acc_next;
        end
        S_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (last_iter) resp_data <= op_rem ? rem_next : quo_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that runs unsigned 32-bit multiply, divide and remainder by iterating on one shared ALU. It sits between the decode/issue stage and the ALU instance, taking ownership of `cmd`/`a`/`b` while busy and releasing the ALU (driving a neutral command) when idle. Requests and results move over independent valid/ready handshakes, so issue stalls rather than drops work.

## Interface
Parameters:
- `ITERS`, 32: iteration count; equals op_t width; other values unsupported.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept (high only in IDLE).
- `req_op`  in  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
- `req_a`  in  32 (op_t)  multiplicand / dividend.
- `req_b`  in  32 (op_t)  multiplier / divisor.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_data`  out  32 (op_t)  result.
- `alu_cmd`  out  alu_cmd_t  to shared ALU `cmd`.
- `alu_a`, `alu_b`  out  32 (op_t)  to shared ALU operands.
- `alu_out`  in  32 (op_t)  from shared ALU result.
- `busy`  out  1  state is MUL or DIV.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset: IDLE, `resp_valid`=0, `resp_data`=0, `busy`=0, `req_ready`=1 from the first cycle after reset.
- IDLE: accept on `req_valid && req_ready`; latch operands, clear accumulator/remainder/quotient, iteration counter = 0.
  - MUL -> MUL. DIVU/REMU with `req_b`≠0 -> DIV.
  - DIVU with `req_b`=0 -> DONE, result 0xFFFF_FFFF. REMU with `req_b`=0 -> DONE, result `req_a`.
  - Reserved op -> DONE, result 0.
- MUL, per cycle (shift-add):
  - `alu_cmd`=ADD, `alu_a`=acc, `alu_b`=mcand.
  - If mplier[0]: acc <= `alu_out`, else acc unchanged.
  - mcand <<= 1; mplier >>= 1; counter++.
  - Counter reaching 32 -> DONE. Overflow beyond bit 31 is discarded.
- DIV, per cycle (restoring, MSB first):
  - t = {rem, dvd[31]} (33 bits).
  - `alu_cmd`=SUB, `alu_a`=t[31:0], `alu_b`=divisor.
  - If t ≥ divisor (33-bit unsigned compare, internal): rem <= `alu_out`, q bit = 1. The 32-bit difference is exact mod 2^32.
  - Otherwise rem <= t[31:0], q bit = 0.
  - dvd <<= 1; counter++. Counter reaching 32 -> DONE.
  - Result: q for DIVU, rem for REMU.
- DONE: `resp_valid`=1 and `resp_data` held stable until `resp_valid && resp_ready`, then -> IDLE.
- In IDLE/DONE: `alu_cmd`=AND, `alu_a`=`alu_b`=0.
- The ALU `overflow` output is ignored.

## Timing
- Request accepted at edge E. Iterations occupy cycles E+1..E+32. `resp_valid` rises at E+33 (33-cycle latency).
- Zero-divisor and reserved ops: `resp_valid` at E+1.
- `req_ready` is combinational from state (IDLE only). No new request is accepted in the cycle a response handshakes; next accept is earliest one cycle later.
- `resp_ready` high on the first DONE cycle: response consumed that cycle.
- `resp_ready` low: DONE holds indefinitely and `busy`=0.
- `rst` in any state, including mid-iteration: next cycle is IDLE. Partial result is discarded, `resp_valid`=0, and the ALU is released the same cycle.
- `req_valid` ignored when not IDLE. Operands are sampled only at accept.

## Configuration
- `ALU_SEQ_EARLY_EXIT_EN` defined: in MUL, if the shifted multiplier (after this cycle's update) is zero, go to DONE next cycle.
  - MUL latency = 1 + (index of highest set bit of `req_b` + 1), minimum 2 cycles (for `req_b`=0).
  - Result is identical to the full 32-iteration run. DIV is unaffected.
- Undefined: MUL always runs 32 iterations (latency 33).

## Test plan
- MUL 0x0000_1234 × 0x0000_5678, `resp_ready`=1 -> `resp_data`=0x0626_0060; `resp_valid` at E+33, or E+16 with `ALU_SEQ_EARLY_EXIT_EN` (highest set bit 14).
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF -> 0x0000_0001 (wrap). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0xFFFF_FFFF/1 -> 0xFFFF_FFFF. DIVU 5/0 -> 0xFFFF_FFFF at E+1. REMU 5/0 -> 5 at E+1.
- Back-pressure: `resp_ready` held low 10 cycles after DONE -> `resp_data` stable, `req_ready`=0, new `req_valid` not accepted. Accept occurs one cycle after the response handshake.
- Assert `rst` at iteration 10 of a DIVU -> next cycle IDLE, `req_ready`=1, `resp_valid`=0, `alu_cmd`=AND. A following MUL 3×4 returns 12.
- Every MUL/DIV cycle: `alu_cmd`/`alu_a`/`alu_b` match the per-cycle rules above (scoreboard checks against a reference model).
